// File: rtl/fft_helpers_twiddle_pkg.sv
// Shared types and elaboration-time helpers for the radix-2 DIT twiddle sequencer.
package fft_helpers_twiddle_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // round(sin(2*pi*i/n) * 2^d), evaluated on the first quadrant and folded by symmetry
    function automatic int twiddle_sine(input int i, input int n, input int d);
        real pi;
        real x;
        real term;
        real acc;
        real scale;
        int  j;
        bit  neg;
        int  mag;
        pi    = 3.14159265358979323846;
        j     = i % n;
        neg   = 1'b0;
        if (j >= n / 2) begin
            neg = 1'b1;
            j   = j - n / 2;
        end
        if (j > n / 4)
            j = n / 2 - j;
        x     = 2.0 * pi * real'(j) / real'(n);
        acc   = x;
        term  = x;
        for (int unsigned t = 1; t <= 12; t++) begin
            term = -term * x * x / real'((2 * t) * (2 * t + 1));
            acc  = acc + term;
        end
        scale = 1.0;
        for (int unsigned t = 0; t < d; t++)
            scale = scale * 2.0;
        mag = $rtoi(acc * scale + 0.5);
        return neg ? -mag : mag;
    endfunction

endpackage

// File: rtl/fft_helpers_twiddle_addr.sv
// Stage/butterfly counter pair; exposes the twiddle index of the position after the next advance.
module fft_helpers_twiddle_addr
    import fft_helpers_twiddle_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          advance,
    output logic [$clog2($clog2(N))-1:0]  s_next,
    output logic [$clog2(N)-1:0]          k_next,
    output logic                          last_next
);

    localparam int LOGN = $clog2(N);
    localparam int S    = LOGN;
    localparam int SW   = $clog2(S);
    localparam int BW   = LOGN - 1;
    localparam logic [BW-1:0]   B_MAX = BW'(N / 2 - 1);
    localparam logic [SW-1:0]   S_MAX = SW'(S - 1);
    localparam logic [LOGN-1:0] ONES  = '1;

    logic [SW-1:0]   s_q;
    logic [BW-1:0]   b_q;
    logic [BW-1:0]   b_n;
    logic            b_wrap;
    logic [LOGN-1:0] bx;
    logic [LOGN-1:0] bmask;

    always_comb begin
        b_wrap = (b_q == B_MAX);
        s_next = b_wrap ? s_q + 1'b1 : s_q;
        b_n    = b_wrap ? '0 : b_q + 1'b1;
        // k = (b mod 2^s) * (N >> (s+1)); the multiply is a left shift by log2(N)-1-s
        bx     = LOGN'(b_n);
        bmask  = ~(ONES << s_next);
        k_next = (bx & bmask) << (LOGN - 1 - int'(s_next));
        last_next = (s_next == S_MAX) && (b_n == B_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            s_q <= '0;
            b_q <= '0;
        end else if (advance) begin
            s_q <= s_next;
            b_q <= b_n;
        end
    end

endmodule

// File: rtl/fft_helpers_twiddle_sequencer.sv
// Streams radix-2 DIT FFT twiddles (stage-major) over valid/ready from an elaboration-time sine table.
// Optional FFT_TWIDDLE_INVERSE_EN adds an 'inverse' input selecting conjugate (+sin) twiddles.
module fft_helpers_twiddle_sequencer
    import fft_helpers_twiddle_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 32,
    parameter int D = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
`ifdef FFT_TWIDDLE_INVERSE_EN
    input  logic                          inverse,
`endif
    output logic                          out_val,
    input  logic                          out_ready,
    output logic [W-1:0]                  out_re,
    output logic [W-1:0]                  out_im,
    output logic [$clog2($clog2(N))-1:0]  out_stage,
    output logic                          out_last,
    output logic                          busy,
    output logic                          done
);

    localparam int LOGN = $clog2(N);
    localparam int SW   = $clog2(LOGN);

    state_t          state;
    logic [W-1:0]    tab [N];
    logic            start_acc;
    logic            advance;
    logic [SW-1:0]   s_next;
    logic [LOGN-1:0] k_next;
    logic            last_next;
    logic [LOGN-1:0] k_sel;
    logic [LOGN-1:0] re_idx;
    logic [LOGN-1:0] im_idx;
    logic            inv_sel;

    for (genvar g = 0; g < N; g++) begin : g_tab
        localparam logic [31:0] EU = 32'(twiddle_sine(g, N, D));
        assign tab[g] = {{(W - D - 1){EU[31]}}, EU[D:0]};
    end

    // a start coinciding with the done pulse is dropped
    assign start_acc = (state == IDLE) && start && !done;
    assign advance   = (state == RUN) && out_ready && !out_last;

    fft_helpers_twiddle_addr #(
        .N(N)
    ) u_addr (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_acc),
        .advance   (advance),
        .s_next    (s_next),
        .k_next    (k_next),
        .last_next (last_next)
    );

`ifdef FFT_TWIDDLE_INVERSE_EN
    logic inv_q;

    always_ff @(posedge clk) begin
        if (reset)
            inv_q <= 1'b0;
        else if (start_acc)
            inv_q <= inverse;
    end

    assign inv_sel = start_acc ? inverse : inv_q;
`else
    assign inv_sel = 1'b0;
`endif

    always_comb begin
        k_sel  = start_acc ? '0 : k_next;
        re_idx = k_sel + LOGN'(N / 4);
        im_idx = inv_sel ? k_sel : k_sel + LOGN'(N / 2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_val   <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_stage <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_acc) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        out_val   <= 1'b1;
                        out_re    <= tab[re_idx];
                        out_im    <= tab[im_idx];
                        out_stage <= '0;
                        out_last  <= 1'b0;
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            out_val <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            out_re    <= tab[re_idx];
                            out_im    <= tab[im_idx];
                            out_stage <= s_next;
                            out_last  <= last_next;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
